mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, data/address width; TIMEOUT, 64, max bus-wait cycles before abort.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- MemReqM  in  1  load/store present in M stage.
- MemWriteM  in  1  1=store, 0=load.
- Funct3M  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResultM  in  WIDTH  byte address.
- WriteDataM  in  WIDTH  store data, LSB-justified.
- ReadDataM  out  WIDTH  extended load result.
- StallM  out  1  hold F/D/E/M pipeline registers.
- MisalignM  out  1  one-cycle misaligned/illegal-access flag.
- BusErrM  out  1  one-cycle timeout flag.
- BusReq  out  1  bus request, held until BusAck.
- BusWe  out  1  bus write enable.
- BusAddr  out  WIDTH  word-aligned address, {ALUResultM[31:2],2'b00}.
- BusWData  out  WIDTH  lane-replicated store data.
- BusBe  out  4  byte enables.
- BusAck  in  1  responder completion, single cycle.
- BusRData  in  WIDTH  read data, valid with BusAck.

Function
REQ-004 The FSM SHALL have states IDLE, BUS, DONE.
REQ-005 In IDLE with MemReqM=1 and access legal, the block SHALL register address, BusWe, BusBe, BusWData, Funct3M, and byte offset; it SHALL move to BUS at the next edge.
REQ-006 In BUS, BusReq SHALL be 1 from a register; all bus outputs SHALL stay stable until BusAck.
REQ-007 In BUS with BusAck=1, the block SHALL latch the extracted load data (0 for stores), clear BusReq, and move to DONE.
REQ-008 In DONE, ReadDataM SHALL be valid for exactly one cycle; no new request SHALL be accepted; the next state SHALL be IDLE.
REQ-009 StallM SHALL be combinational: 1 when (IDLE and MemReqM and legal) or BUS; otherwise 0, including in DONE.
REQ-010 Minimum access time SHALL be 3 cycles (IDLE, BUS with ack, DONE); each BusAck-free BUS cycle SHALL add 1 cycle.
REQ-011 An access SHALL be illegal when: H/HU/SH and addr[0]=1; W and addr[1:0]!=0; or Funct3M in {011,110,111}; or a store with Funct3M[2]=1.
REQ-012 An illegal access SHALL set MisalignM=1 for that IDLE cycle, keep StallM=0, issue no bus request, and force ReadDataM=0.
REQ-013 Store lanes: SB BusWData={4{b}}, BusBe=0001<<addr[1:0]; SH {2{h}}, BusBe=0011 (addr[1]=0) or 1100; SW BusBe=1111.
REQ-014 Loads SHALL select byte addr[1:0] or half addr[1]; B/H sign-extend, BU/HU zero-extend, W pass through.
REQ-015 A wait counter SHALL clear on BUS entry and increment per BUS cycle without BusAck.
REQ-016 When the counter reaches TIMEOUT-1 with no BusAck, the block SHALL move to DONE with ReadDataM=0, BusErrM=1 for one cycle, and BusReq dropped.
REQ-017 A BusAck coinciding with timeout expiry SHALL take priority: data accepted, BusErrM=0.
REQ-018 BusAck received outside BUS SHALL be ignored.
REQ-019 ReadDataM SHALL hold its last value outside DONE and illegal-access cycles.

Reset
REQ-020 With RST_N=0 at a rising edge, the block SHALL set state=IDLE, BusReq=0, BusWe=0, BusBe=0, BusAddr=0, BusWData=0, ReadDataM=0, MisalignM=0, BusErrM=0, counter=0.
REQ-021 Reset in BUS SHALL abandon the transaction; BusReq SHALL be 0 after that edge; no BusErrM or MisalignM SHALL pulse.

Verification
REQ-022 LW at 0x100, BusAck on first BUS cycle, BusRData=0xDEADBEEF -> StallM=1,1,0; ReadDataM=0xDEADBEEF in DONE; BusAddr=0x100, BusBe=1111.
REQ-023 LB at 0x103, BusRData=0x80FF_FF7F -> ReadDataM=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x102 -> 0x000080FF.
REQ-024 SH at 0x206, WriteDataM=0x1234ABCD -> BusWe=1, BusBe=1100, BusWData=0xABCDABCD, BusAddr=0x204.
REQ-025 LW at 0x101 -> MisalignM=1 for 1 cycle, StallM=0, BusReq never 1, ReadDataM=0.
REQ-026 LW with BusAck held 0 and TIMEOUT=64 -> BusReq high for 64 cycles, then DONE with BusErrM=1 and ReadDataM=0; repeat with BusAck on the 64th cycle -> data accepted, BusErrM=0.
REQ-027 RST_N=0 during the 3rd BUS cycle -> next cycle IDLE, BusReq=0, StallM=0; a later BusAck is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit for the M stage: checks alignment, drives a
// single-outstanding request/acknowledge bus, and returns the sign- or
// zero-extended load result.
module mem_access_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             MemReqM,
    input  logic             MemWriteM,
    input  logic [2:0]       Funct3M,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             StallM,
    output logic             MisalignM,
    output logic             BusErrM,
    output logic             BusReq,
    output logic             BusWe,
    output logic [WIDTH-1:0] BusAddr,
    output logic [WIDTH-1:0] BusWData,
    output logic [3:0]       BusBe,
    input  logic             BusAck,
    input  logic [WIDTH-1:0] BusRData
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_bus_req;
    logic             r_bus_we;
    logic [WIDTH-1:0] r_bus_addr;
    logic [WIDTH-1:0] r_bus_wdata;
    logic [3:0]       r_bus_be;
    logic [2:0]       r_f3;
    logic [1:0]       r_off;
    logic [WIDTH-1:0] r_rdata;
    logic             r_err;

    logic             w_legal;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wdata;
    logic [7:0]       w_lane [4];
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_load;
    logic             w_accept;
    logic             w_illegal;

    // Split the returned word into byte lanes for load extraction.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = BusRData[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_lane[r_off];
    assign w_half = r_off[1] ? {w_lane[3], w_lane[2]} : {w_lane[1], w_lane[0]};

    // Legality: unsupported encodings, unsigned stores and natural misalignment are rejected.
    always_comb begin
        w_legal = 1'b0;
        case (Funct3M)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~ALUResultM[0];
            3'b010:  w_legal = (ALUResultM[1:0] == 2'b00);
            3'b100:  w_legal = ~MemWriteM;
            3'b101:  w_legal = ~MemWriteM & ~ALUResultM[0];
            default: w_legal = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data from access size and offset.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALUResultM[1:0];
                w_wdata = {(WIDTH/8){WriteDataM[7:0]}};
            end
            2'b01: begin
                w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {(WIDTH/16){WriteDataM[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = WriteDataM;
            end
        endcase
    end

    // Load result extraction using the size/sign captured at request time.
    always_comb begin
        w_load = BusRData;
        case (r_f3)
            3'b000:  w_load = {{(WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load = {{(WIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_load = {{(WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load = {{(WIDTH-16){1'b0}}, w_half};
            default: w_load = BusRData;
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && MemReqM && w_legal;
    assign w_illegal = (r_state == S_IDLE) && MemReqM && !w_legal;

    // Access sequencer: IDLE accepts, BUS waits for ack or timeout, DONE presents the result.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= 4'b0000;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_err <= 1'b0;
                    if (w_accept) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= MemWriteM;
                        r_bus_addr  <= {ALUResultM[WIDTH-1:2], 2'b00};
                        r_bus_wdata <= w_wdata;
                        r_bus_be    <= w_be;
                        r_f3        <= Funct3M;
                        r_off       <= ALUResultM[1:0];
                        r_cnt       <= '0;
                        r_state     <= S_BUS;
                    end else if (w_illegal) begin
                        r_rdata <= '0;
                    end
                end
                S_BUS: begin
                    if (BusAck) begin
                        // An ack on the final wait cycle still wins over the timeout.
                        r_rdata   <= r_bus_we ? '0 : w_load;
                        r_bus_req <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_bus_req <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign StallM    = w_accept || (r_state == S_BUS);
    assign MisalignM = w_illegal;
    assign ReadDataM = w_illegal ? '0 : r_rdata;
    assign BusErrM   = r_err;
    assign BusReq    = r_bus_req;
    assign BusWe     = r_bus_we;
    assign BusAddr   = r_bus_addr;
    assign BusWData  = r_bus_wdata;
    assign BusBe     = r_bus_be;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level reference model with a
// per-cycle compare process, directed literal cases and random accesses.
module tb_mem_access_unit;

    localparam int TIMEOUT = 64;

    logic        CLK;
    logic        RST_N;
    logic        MemReqM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        BusErrM;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [31:0] BusWData;
    logic [3:0]  BusBe;
    logic        BusAck;
    logic [31:0] BusRData;

    mem_access_unit #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .MemReqM    (MemReqM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .BusReq     (BusReq),
        .BusWe      (BusWe),
        .BusAddr    (BusAddr),
        .BusWData   (BusWData),
        .BusBe      (BusBe),
        .BusAck     (BusAck),
        .BusRData   (BusRData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Expected outputs for the current cycle, set by the driver
    logic        e_valid = 1'b0;
    logic        e_stall, e_mis, e_err, e_req, e_zero, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    logic [31:0] last_rdata = 32'h0;

    // Observations for literal checks
    logic [7:0]  cap_stall = 8'h0;
    logic [31:0] cap_rdata, cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we, cap_err;
    int          cap_req_cycles = 0;
    int          cap_mis_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 >= 3'd6) return 1'b0;
        if (we && f3 >= 3'd4) return 1'b0;
        return (a % m_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int v;
        v = ((1 << m_size(f3)) - 1) << (a % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (m_size(f3) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (m_size(f3) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        bit sgn;
        sgn = (f3 < 3'd4);
        v = rd >> (8 * (a % 4));
        if (m_size(f3) == 1) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (m_size(f3) == 2) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (e_valid) begin
            chk("StallM", 32'(StallM), 32'(e_stall));
            chk("MisalignM", 32'(MisalignM), 32'(e_mis));
            chk("BusErrM", 32'(BusErrM), 32'(e_err));
            chk("BusReq", 32'(BusReq), 32'(e_req));
            chk("ReadDataM", ReadDataM, e_rdata);
            if (e_req) begin
                chk("BusWe", 32'(BusWe), 32'(e_we));
                chk("BusAddr", BusAddr, e_addr);
                chk("BusBe", 32'(BusBe), 32'(e_be));
                chk("BusWData", BusWData, e_wdata);
            end
            if (e_zero) begin
                chk("rst_BusWe", 32'(BusWe), 32'h0);
                chk("rst_BusAddr", BusAddr, 32'h0);
                chk("rst_BusBe", 32'(BusBe), 32'h0);
                chk("rst_BusWData", BusWData, 32'h0);
            end
            cap_stall = {cap_stall[6:0], StallM};
            cap_rdata = ReadDataM;
            cap_err   = BusErrM;
            if (BusReq) begin
                cap_req_cycles++;
                cap_addr  = BusAddr;
                cap_be    = BusBe;
                cap_wdata = BusWData;
                cap_we    = BusWe;
            end
            if (MisalignM) cap_mis_cycles++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle_exp();
        e_valid = 1'b1;
        e_stall = 1'b0;
        e_mis   = 1'b0;
        e_err   = 1'b0;
        e_req   = 1'b0;
        e_zero  = 1'b0;
        e_rdata = last_rdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            MemReqM  = 1'b0;
            BusAck   = 1'($urandom);
            BusRData = $urandom;
            set_idle_exp();
        end
    endtask

    task automatic set_bus_exp(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        e_valid = 1'b1;
        e_req   = 1'b1;
        e_stall = 1'b1;
        e_mis   = 1'b0;
        e_err   = 1'b0;
        e_zero  = 1'b0;
        e_we    = we;
        e_addr  = addr & ~32'h3;
        e_be    = m_be(f3, addr);
        e_wdata = m_wdata(f3, wd);
        e_rdata = last_rdata;
    endtask

    // One access starting in IDLE; ack_delay >= TIMEOUT means no ack at all.
    task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int ack_delay, input bit done_req);
        bit legal;
        bit acked;
        legal = m_legal(we, f3, addr);
        @(posedge CLK); #1;
        MemReqM    = 1'b1;
        MemWriteM  = we;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        BusAck     = 1'($urandom);
        BusRData   = $urandom;
        cap_req_cycles = 0;
        cap_mis_cycles = 0;
        set_idle_exp();
        if (!legal) begin
            e_mis      = 1'b1;
            last_rdata = 32'h0;
            e_rdata    = 32'h0;
        end else begin
            e_stall = 1'b1;
            acked   = 1'b0;
            for (int k = 0; k < TIMEOUT; k++) begin
                @(posedge CLK); #1;
                acked    = (k == ack_delay);
                BusAck   = acked;
                BusRData = acked ? rd : $urandom;
                set_bus_exp(we, f3, addr, wd);
                if (acked) break;
            end
            @(posedge CLK); #1;
            MemReqM  = done_req;
            BusAck   = 1'($urandom);
            BusRData = $urandom;
            set_idle_exp();
            e_err      = !acked;
            e_rdata    = (!acked || we) ? 32'h0 : m_load(f3, addr, rd);
            last_rdata = e_rdata;
        end
        @(negedge CLK); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N      = 1'b0;
        MemReqM    = 1'b0;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b000;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        BusAck     = 1'b0;
        BusRData   = 32'h0;
        e_valid    = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        last_rdata = 32'h0;
        set_idle_exp();
        e_zero = 1'b1;
        idle(2);

        // LW 0x100, immediate ack
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        $display("txn LW  0x100 -> %h", cap_rdata);
        chk("lw_rdata", cap_rdata, 32'hDEAD_BEEF);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_be", 32'(cap_be), 32'hF);
        chk("lw_stall_trace", 32'(cap_stall[2:0]), 32'h6);
        chk("lw_req_cycles", 32'(cap_req_cycles), 32'd1);
        idle(1);

        do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 1, 1'b0);
        $display("txn LB  0x103 -> %h", cap_rdata);
        chk("lb_rdata", cap_rdata, 32'hFFFF_FF80);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 1'b1);
        $display("txn LBU 0x103 -> %h", cap_rdata);
        chk("lbu_rdata", cap_rdata, 32'h0000_0080);
        do_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_FF7F, 2, 1'b0);
        $display("txn LHU 0x102 -> %h", cap_rdata);
        chk("lhu_rdata", cap_rdata, 32'h0000_80FF);

        // Misaligned LW
        do_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h1111_1111, 0, 1'b0);
        $display("txn LW  0x101 misaligned, rdata=%h", cap_rdata);
        chk("mis_cycles", 32'(cap_mis_cycles), 32'd1);
        chk("mis_req_cycles", 32'(cap_req_cycles), 32'd0);
        chk("mis_rdata", cap_rdata, 32'h0);
        chk("mis_stall", 32'(cap_stall[0]), 32'h0);
        idle(1);

        do_access(1'b1, 3'b001, 32'h206, 32'h1234_ABCD, 32'h0, 0, 1'b0);
        $display("txn SH  0x206 be=%h wdata=%h", cap_be, cap_wdata);
        chk("sh_we", 32'(cap_we), 32'h1);
        chk("sh_be", 32'(cap_be), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_addr", cap_addr, 32'h204);

        // Timeout, then ack on the last wait cycle
        do_access(1'b0, 3'b010, 32'h300, 32'h0, 32'h2468_ACE0, TIMEOUT, 1'b0);
        $display("txn LW  0x300 timeout req_cycles=%0d err=%0d", cap_req_cycles, cap_err);
        chk("to_req_cycles", 32'(cap_req_cycles), 32'd64);
        chk("to_err", 32'(cap_err), 32'h1);
        chk("to_rdata", cap_rdata, 32'h0);
        idle(1);
        do_access(1'b0, 3'b010, 32'h300, 32'h0, 32'h1357_9BDF, TIMEOUT - 1, 1'b0);
        $display("txn LW  0x300 late ack req_cycles=%0d err=%0d", cap_req_cycles, cap_err);
        chk("late_req_cycles", 32'(cap_req_cycles), 32'd64);
        chk("late_err", 32'(cap_err), 32'h0);
        chk("late_rdata", cap_rdata, 32'h1357_9BDF);
        idle(1);

        // Reset during the third BUS cycle
        @(posedge CLK); #1;
        MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010;
        ALUResultM = 32'h400; BusAck = 1'b0;
        cap_req_cycles = 0;
        set_idle_exp();
        e_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            BusAck = 1'b0;
            set_bus_exp(1'b0, 3'b010, 32'h400, 32'h0);
            if (k == 2) RST_N = 1'b0;
        end
        @(posedge CLK); #1;
        RST_N = 1'b1; MemReqM = 1'b0; BusAck = 1'b1; BusRData = 32'hCAFE_F00D;
        last_rdata = 32'h0;
        set_idle_exp();
        e_zero = 1'b1;
        @(posedge CLK); #1;
        BusAck = 1'b1;
        set_idle_exp();
        @(negedge CLK); #1;
        $display("txn LW  0x400 reset mid-bus req_cycles=%0d", cap_req_cycles);
        chk("rst_req_cycles", 32'(cap_req_cycles), 32'd3);
        idle(1);

        // Random accesses
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, wd, rd;
            bit          we;
            int          d;
            f3 = 3'($urandom);
            we = 1'($urandom);
            a  = $urandom;
            wd = $urandom;
            rd = $urandom;
            d  = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 4, TIMEOUT) : $urandom_range(0, 3);
            do_access(we, f3, a, wd, rd, d, 1'($urandom));
            $display("txn rnd %0d we=%0d f3=%0d addr=%h rdata=%h err=%0d", n, we, f3, a, cap_rdata, cap_err);
            idle($urandom_range(0, 2));
        end

        idle(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
